adder_sequencer: RTL

ADDER_SEQUENCER -- requirements
Module: adder_sequencer

---
 rtl/adder_seq_pkg.sv | 17 +
 rtl/adder_sequencer_if.sv | 59 +++++
 rtl/adder_sequencer_rr_arbiter2.sv | 23 ++
 rtl/adder_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the adder sequencer slice.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
//
// Contents: the default datapath width and the sequencer state encoding.
package adder_seq_pkg;

    localparam int ADD_SEQ_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } seq_state_t;

endpackage

// File: rtl/adder_sequencer_if.sv
// Bundle of the two requester ports, the shared-adder port and the response port.
// Latency: none (wiring only).
// Backpressure: requests stall on reqN_ready, the response stalls on rsp_ready.
//
// Modports: slave  = the sequencer (accepts requests, drives adder operands, returns results)
//           master = the environment (requesters, the external prefix adder, the consumer)
interface adder_sequencer_if
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = ADD_SEQ_WIDTH
) ();

    logic               req0_valid;
    logic               req0_ready;
    logic [2*WIDTH-1:0] req0_a;
    logic [2*WIDTH-1:0] req0_b;
    logic               req0_sub;
    logic               req0_wide;

    logic               req1_valid;
    logic               req1_ready;
    logic [2*WIDTH-1:0] req1_a;
    logic [2*WIDTH-1:0] req1_b;
    logic               req1_sub;
    logic               req1_wide;

    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [2*WIDTH-1:0] rsp_sum;
    logic               rsp_cout;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub, req0_wide,
        input  req1_valid, req1_a, req1_b, req1_sub, req1_wide,
        output req0_ready, req1_ready,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub, req0_wide,
        output req1_valid, req1_a, req1_b, req1_sub, req1_wide,
        input  req0_ready, req1_ready,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
        output rsp_ready
    );

endinterface

// File: rtl/adder_sequencer_rr_arbiter2.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the side not granted last.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own ready condition.
//
// Ports: i_valid0/i_valid1 request lines, i_last_grant index of the previous winner,
//        o_grant one-hot grant (bit N set only when i_validN is set).
module rr_arbiter2 (
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_valid0 && i_valid1) begin
            o_grant = i_last_grant ? 2'b01 : 2'b10;
        end else begin
            o_grant = {i_valid1, i_valid0};
        end
    end

endmodule

// File: rtl/adder_sequencer.sv
// Time-shares one external WIDTH-bit prefix adder between two requesters for add/sub ops.
// Latency: response valid 2 cycles after the handshake (narrow), 3 cycles (wide).
// Backpressure: one op in flight; requesters see ready only in IDLE, result held until rsp_ready.
//
// Ports: clk, rst_n (synchronous, active-low) and bus (adder_sequencer_if.slave) carrying
//        req0_*/req1_* request channels, add_* adder channel and rsp_* result channel.
module adder_sequencer
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = ADD_SEQ_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    adder_sequencer_if.slave  bus
);

    seq_state_t         r_state;
    logic               r_last_grant;
    logic [2*WIDTH-1:0] r_a;
    logic [2*WIDTH-1:0] r_b;
    logic               r_sub;
    logic               r_wide;
    logic               r_id;
    logic [WIDTH-1:0]   r_sum_lo;
    logic               r_cout_lo;

    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [2*WIDTH-1:0] r_rsp_sum;
    logic               r_rsp_cout;

    logic [1:0]         w_grant;
    logic               w_idle;
    logic               w_hs0;
    logic               w_hs1;
    logic [2*WIDTH-1:0] w_a_sel;
    logic [2*WIDTH-1:0] w_b_sel;
    logic               w_sub_sel;
    logic               w_wide_sel;

    rr_arbiter2 u_arb (
        .i_valid0     (bus.req0_valid),
        .i_valid1     (bus.req1_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Gating with rst_n keeps ready low in the reset cycle even though the
    // state register only clears on the edge that ends it.
    assign w_idle = rst_n && (r_state == IDLE);
    assign w_hs0  = w_idle && w_grant[0];
    assign w_hs1  = w_idle && w_grant[1];

    assign bus.req0_ready = w_hs0;
    assign bus.req1_ready = w_hs1;

    assign w_a_sel    = w_grant[1] ? bus.req1_a    : bus.req0_a;
    assign w_b_sel    = w_grant[1] ? bus.req1_b    : bus.req0_b;
    assign w_sub_sel  = w_grant[1] ? bus.req1_sub  : bus.req0_sub;
    assign w_wide_sel = w_grant[1] ? bus.req1_wide : bus.req0_wide;

    // Subtraction is a + ~b + 1: the +1 enters as carry-in of the low pass and
    // then ripples into the high pass through the registered low carry.
    always_comb begin
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        case (r_state)
            LO: begin
                bus.add_a   = r_a[WIDTH-1:0];
                bus.add_b   = r_b[WIDTH-1:0] ^ {WIDTH{r_sub}};
                bus.add_cin = r_sub;
            end
            HI: begin
                bus.add_a   = r_a[2*WIDTH-1:WIDTH];
                bus.add_b   = r_b[2*WIDTH-1:WIDTH] ^ {WIDTH{r_sub}};
                bus.add_cin = r_cout_lo;
            end
            default: begin
                bus.add_a   = '0;
                bus.add_b   = '0;
                bus.add_cin = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_sub        <= 1'b0;
            r_wide       <= 1'b0;
            r_id         <= 1'b0;
            r_sum_lo     <= '0;
            r_cout_lo    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_sum    <= '0;
            r_rsp_cout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs0 || w_hs1) begin
                        r_a          <= w_a_sel;
                        r_b          <= w_b_sel;
                        r_sub        <= w_sub_sel;
                        r_wide       <= w_wide_sel;
                        r_id         <= w_hs1;
                        r_last_grant <= w_hs1;
                        r_state      <= LO;
                    end
                end
                LO: begin
                    r_sum_lo  <= bus.add_sum;
                    r_cout_lo <= bus.add_cout;
                    if (r_wide) begin
                        r_state <= HI;
                    end else begin
                        // Narrow result: upper half forced to zero, carry is the low pass carry.
                        r_rsp_sum   <= {{WIDTH{1'b0}}, bus.add_sum};
                        r_rsp_cout  <= bus.add_cout;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                HI: begin
                    r_rsp_sum   <= {bus.add_sum, r_sum_lo};
                    r_rsp_cout  <= bus.add_cout;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_cout  = r_rsp_cout;

endmodule
